// File: rtl/pipelined_addsub_nbit.sv
// -----------------------------------------------------------------------------
// pipelined_addsub_nbit
//   WIDTH-bit adder/subtractor. The carry chain is cut into STAGES registered
//   ripple segments of CHUNK = WIDTH/STAGES bits, so one result per cycle at
//   STAGES cycles of latency.
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous, active-high reset
//   in_valid   operand beat valid
//   in_ready   beat can be accepted this cycle (combinational)
//   a, b       operands
//   cin        carry-in (borrow-in when sub=1)
//   sub        0: a+b+cin   1: a-b-cin
//   out_valid  result beat valid
//   out_ready  downstream accepts result
//   sum        result modulo 2^WIDTH
//   cout       carry out of MSB (sub: 1 = no borrow)
//   overflow   signed overflow
// -----------------------------------------------------------------------------
module pipelined_addsub_nbit #(
  parameter int WIDTH  = 16,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow
);

  localparam int CHUNK = WIDTH / STAGES;

  if (STAGES < 1 || (WIDTH % STAGES) != 0) begin : g_bad_cfg
    $error("pipelined_addsub_nbit: WIDTH (%0d) must be a multiple of STAGES (%0d)",
           WIDTH, STAGES);
  end

  // Whole pipeline moves together; it only stops when the output holds an
  // unconsumed beat. Bubbles are carried, never collapsed.
  logic advance;
  assign advance  = !g_stg[STAGES-1].v_q || out_ready;
  assign in_ready = advance;

  for (genvar k = 0; k < STAGES; k++) begin : g_stg
    localparam int UPW = WIDTH - k*CHUNK;  // operand bits not yet consumed
    localparam int SW  = (k+1)*CHUNK;      // sum bits known after this stage

    logic [UPW-1:0]   a_x, b_x;            // stage inputs
    logic             c_x, v_x;
    logic [CHUNK-1:0] sl;                  // this stage's sum slice
    logic [CHUNK:0]   cc;                  // ripple carries
    logic             co;
    logic [SW-1:0]    s_d, s_q;            // deskewed sum, low bits
    logic             c_q, v_q;

    if (k == 0) begin : g_in
      // Subtraction folds into the add as a + ~b + !cin.
      assign a_x = a;
      assign b_x = b ^ {WIDTH{sub}};
      assign c_x = cin ^ sub;
      assign v_x = in_valid;
      assign s_d = sl;
    end else begin : g_in
      assign a_x = g_stg[k-1].g_skew.a_q;
      assign b_x = g_stg[k-1].g_skew.b_q;
      assign c_x = g_stg[k-1].c_q;
      assign v_x = g_stg[k-1].v_q;
      assign s_d = {sl, g_stg[k-1].s_q};
    end

    always_comb begin
      cc    = '0;
      sl    = '0;
      cc[0] = c_x;
      for (int i = 0; i < CHUNK; i++) begin
        sl[i]   = a_x[i] ^ b_x[i] ^ cc[i];
        cc[i+1] = (a_x[i] & b_x[i]) | (cc[i] & (a_x[i] ^ b_x[i]));
      end
    end
    assign co = cc[CHUNK];

    // Bubble data is zeroed so idle slots read as clean zeros.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        v_q <= 1'b0;
        c_q <= 1'b0;
        s_q <= '0;
      end else if (advance) begin
        v_q <= v_x;
        c_q <= v_x & co;
        s_q <= v_x ? s_d : '0;
      end
    end

    if (k < STAGES-1) begin : g_skew
      // Upper operand bits waiting for their stage.
      logic [UPW-CHUNK-1:0] a_q, b_q;
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          a_q <= '0;
          b_q <= '0;
        end else if (advance) begin
          a_q <= v_x ? a_x[UPW-1:CHUNK] : '0;
          b_q <= v_x ? b_x[UPW-1:CHUNK] : '0;
        end
      end
    end else begin : g_last
      // Carry into the MSB recovered from the MSB sum bit (s = a^b^cin);
      // with CHUNK=1 this is just the registered carry of the prior stage.
      logic cm;
      logic ovf_q;
      assign cm = a_x[CHUNK-1] ^ b_x[CHUNK-1] ^ sl[CHUNK-1];
      always_ff @(posedge clk or posedge rst) begin
        if (rst)          ovf_q <= 1'b0;
        else if (advance) ovf_q <= v_x & (cm ^ co);
      end
    end
  end

  assign out_valid = g_stg[STAGES-1].v_q;
  assign sum       = g_stg[STAGES-1].s_q;
  assign cout      = g_stg[STAGES-1].c_q;
  assign overflow  = g_stg[STAGES-1].g_last.ovf_q;

endmodule

// File: tb/tb_pipelined_addsub_nbit.sv
module tb_pipelined_addsub_nbit;
  localparam int W = 16;
  localparam int S = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid, in_ready, cin, sub, out_valid, out_ready, cout, overflow;
  logic [W-1:0] a, b, sum;

  always #5 clk = ~clk;

  pipelined_addsub_nbit #(.WIDTH(W), .STAGES(S)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .sub(sub),
    .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout), .overflow(overflow)
  );

  typedef struct {
    logic [15:0] s;
    logic        c;
    logic        o;
    int          cyc;
    bit          lat;
  } exp_t;

  exp_t        q[$];
  exp_t        nxt;
  int          errors = 0, checks = 0, cyc = 0;
  bit          acc, lat_on, stall_prev;
  logic [17:0] held;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic exp_t mk(input logic [15:0] s, input logic c, input logic o);
    exp_t e;
    e.s = s; e.c = c; e.o = o; e.cyc = 0; e.lat = 0;
    return e;
  endfunction

  // Plain integer arithmetic: unsigned result for sum/cout, signed result
  // for overflow.
  function automatic exp_t model(input logic [15:0] a_, input logic [15:0] b_,
                                 input logic ci, input logic sb);
    int ua, ub, sa, sbv, r, sr;
    exp_t e;
    ua = int'(a_);  ub  = int'(b_);
    sa = int'($signed(a_)); sbv = int'($signed(b_));
    if (!sb) begin
      r  = ua + ub + int'(ci);
      sr = sa + sbv + int'(ci);
      e.c = (r > 65535);
    end else begin
      r  = ua - ub - int'(ci);
      sr = sa - sbv - int'(ci);
      e.c = (r >= 0);
    end
    e.s = r[15:0];
    e.o = (sr > 32767) || (sr < -32768);
    e.cyc = 0; e.lat = 0;
    return e;
  endfunction

  // One cycle: sample at negedge, score retiring beat, record accepted beat.
  task automatic tick();
    @(negedge clk);
    chk("in_ready", 32'(in_ready), 32'(!out_valid || out_ready));
    if (stall_prev) chk("stall_hold", 32'({sum, cout, overflow}), 32'(held));
    if (out_valid && out_ready) begin
      if (q.size() == 0) chk("spurious_out", 32'(out_valid), 32'(0));
      else begin
        exp_t e = q.pop_front();
        chk("sum",  32'(sum),      32'(e.s));
        chk("cout", 32'(cout),     32'(e.c));
        chk("ovf",  32'(overflow), 32'(e.o));
        if (e.lat) chk("latency", 32'(cyc - e.cyc), 32'(S));
      end
    end
    acc = in_valid && in_ready;
    if (acc) begin
      nxt.cyc = cyc; nxt.lat = lat_on;
      q.push_back(nxt);
    end
    stall_prev = out_valid && !out_ready;
    held = {sum, cout, overflow};
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic send(input logic [15:0] a_, input logic [15:0] b_,
                      input logic ci, input logic sb, input exp_t e);
    a = a_; b = b_; cin = ci; sub = sb; in_valid = 1'b1; nxt = e;
    for (int n = 0; n < 20; n++) begin
      tick();
      if (acc) break;
    end
    if (!acc) chk("send_timeout", 32'(acc), 32'(1));
    in_valid = 1'b0;
  endtask

  task automatic send_rnd();
    logic [15:0] ra, rb;
    logic rc, rs;
    ra = 16'($urandom); rb = 16'($urandom);
    rc = 1'($urandom);  rs = 1'($urandom);
    send(ra, rb, rc, rs, model(ra, rb, rc, rs));
  endtask

  task automatic drain();
    in_valid = 1'b0;
    for (int n = 0; n < 40 && q.size() > 0; n++) tick();
    chk("drain_empty", 32'(q.size()), 32'(0));
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0;
    out_ready = 1'b1; lat_on = 1'b1; stall_prev = 1'b0; held = '0;
    #2;
    chk("rst_out_valid", 32'(out_valid), 32'(0));
    chk("rst_sum",       32'(sum),       32'(0));
    chk("rst_cout",      32'(cout),      32'(0));
    chk("rst_ovf",       32'(overflow),  32'(0));
    chk("rst_in_ready",  32'(in_ready),  32'(1));
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;

    // carry across the stage 1/2 boundary
    send(16'h00FF, 16'h0001, 1'b0, 1'b0, mk(16'h0100, 1'b0, 1'b0));
    drain();
    // wrap-around and signed overflow
    send(16'hFFFF, 16'h0001, 1'b0, 1'b0, mk(16'h0000, 1'b1, 1'b0));
    send(16'h7FFF, 16'h0001, 1'b0, 1'b0, mk(16'h8000, 1'b0, 1'b1));
    drain();
    // subtract
    send(16'h0005, 16'h0007, 1'b0, 1'b1, mk(16'hFFFE, 1'b0, 1'b0));
    send(16'h0009, 16'h0003, 1'b1, 1'b1, mk(16'h0005, 1'b1, 1'b0));
    send(16'h8000, 16'h0001, 1'b0, 1'b1, mk(16'h7FFF, 1'b1, 1'b1));
    drain();

    // throughput: 8 back-to-back random beats
    for (int i = 0; i < 8; i++) send_rnd();
    drain();

    // backpressure: 6 beats, output held off for 3 cycles
    lat_on = 1'b0;
    for (int i = 0; i < 4; i++) send_rnd();
    chk("bp_pre_valid", 32'(out_valid), 32'(1));
    begin
      logic [15:0] ra, rb;
      logic rc, rs;
      ra = 16'($urandom); rb = 16'($urandom); rc = 1'($urandom); rs = 1'($urandom);
      out_ready = 1'b0;
      a = ra; b = rb; cin = rc; sub = rs; in_valid = 1'b1; nxt = model(ra, rb, rc, rs);
      repeat (3) begin
        tick();
        chk("bp_not_taken", 32'(acc), 32'(0));
      end
      out_ready = 1'b1;
      send(ra, rb, rc, rs, model(ra, rb, rc, rs));
    end
    send_rnd();
    drain();
    lat_on = 1'b1;

    // reset mid-flight
    for (int i = 0; i < 3; i++) send_rnd();
    tick();
    chk("rst_pre_valid", 32'(out_valid), 32'(1));
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_out_valid", 32'(out_valid), 32'(0));
    chk("mid_rst_sum",       32'(sum),       32'(0));
    chk("mid_rst_cout",      32'(cout),      32'(0));
    chk("mid_rst_ovf",       32'(overflow),  32'(0));
    chk("mid_rst_in_ready",  32'(in_ready),  32'(1));
    q.delete();
    stall_prev = 1'b0;
    @(posedge clk); #1;
    chk("rst_hold_valid", 32'(out_valid), 32'(0));
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;
    send(16'h1234, 16'h4321, 1'b1, 1'b0, mk(16'h5556, 1'b0, 1'b0));
    in_valid = 1'b0;
    repeat (12) tick();
    chk("post_rst_empty", 32'(q.size()), 32'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
